// File: rtl/if_id_decode_stage.sv
// rtl/if_id_decode_stage.sv - IF/ID pipeline register with 2-entry skid buffer and MIPS field split
// Optional: define IFID_PERF_CNT_EN to add saturating stall/bubble performance counters.
module if_id_decode_stage #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [PC_W-1:0] out_pc_plus4,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [15:0]     out_imm,
    output logic [25:0]     out_jaddr
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    // Head (H) is what downstream sees; skid (S) catches the one beat
    // in flight when downstream stalls, since in_ready is registered.
    logic            h_valid, s_valid;
    logic [31:0]     h_instr, s_instr;
    logic [PC_W-1:0] h_pc, s_pc;

    logic            h_valid_n, s_valid_n;
    logic [31:0]     h_instr_n, s_instr_n;
    logic [PC_W-1:0] h_pc_n, s_pc_n;

    logic accept;
    logic consume;

    assign accept  = in_valid && in_ready;
    assign consume = h_valid && out_ready;

    // Next-state selection: flush, then refill H (S first to keep FIFO order), then park in S.
    always_comb begin
        h_valid_n = h_valid;
        s_valid_n = s_valid;
        h_instr_n = h_instr;
        h_pc_n    = h_pc;
        s_instr_n = s_instr;
        s_pc_n    = s_pc;
        if (flush) begin
            h_valid_n = 1'b0;
            s_valid_n = 1'b0;
        end else if (!h_valid || consume) begin
            if (s_valid) begin
                h_valid_n = 1'b1;
                h_instr_n = s_instr;
                h_pc_n    = s_pc;
                if (accept) begin
                    s_instr_n = in_instr;
                    s_pc_n    = in_pc;
                end else begin
                    s_valid_n = 1'b0;
                end
            end else if (accept) begin
                h_valid_n = 1'b1;
                h_instr_n = in_instr;
                h_pc_n    = in_pc;
            end else begin
                h_valid_n = 1'b0;
            end
        end else if (accept) begin
            s_valid_n = 1'b1;
            s_instr_n = in_instr;
            s_pc_n    = in_pc;
        end
    end

    // Buffer state and registered in_ready (ready whenever the skid slot will be free).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid  <= 1'b0;
            s_valid  <= 1'b0;
            h_instr  <= '0;
            h_pc     <= '0;
            s_instr  <= '0;
            s_pc     <= '0;
            in_ready <= 1'b1;
        end else begin
            h_valid  <= h_valid_n;
            s_valid  <= s_valid_n;
            h_instr  <= h_instr_n;
            h_pc     <= h_pc_n;
            s_instr  <= s_instr_n;
            s_pc     <= s_pc_n;
            in_ready <= !s_valid_n;
        end
    end

    logic [31:0]     v_instr;
    logic [PC_W-1:0] v_pc;

    // Field views of the head entry, zeroed while it is empty.
    always_comb begin
        v_instr      = h_valid ? h_instr : 32'd0;
        v_pc         = h_valid ? h_pc : '0;
        out_valid    = h_valid;
        out_pc       = v_pc;
        out_pc_plus4 = h_valid ? (h_pc + PC_W'(4)) : '0;
        out_opcode   = v_instr[31:26];
        out_rs       = v_instr[25:21];
        out_rt       = v_instr[20:16];
        out_rd       = v_instr[15:11];
        out_shamt    = v_instr[10:6];
        out_funct    = v_instr[5:0];
        out_imm      = v_instr[15:0];
        out_jaddr    = v_instr[25:0];
    end

`ifdef IFID_PERF_CNT_EN
    // Saturating counters of upstream stalls and downstream bubbles; flush does not touch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (out_ready && !h_valid && (perf_bubble_cnt != 32'hFFFF_FFFF))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_decode_stage.sv
// tb/tb_if_id_decode_stage.sv - self-checking bench for if_id_decode_stage
module tb_if_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_pc_plus4;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] out_imm;
    logic [25:0] out_jaddr;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_decode_stage #(.PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm), .out_jaddr(out_jaddr)
`ifdef IFID_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; flush = 0; out_ready = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++;
        if ({out_pc, out_pc_plus4, out_jaddr, out_rd} !== 95'd0) begin
            errors++; $display("FAIL reset_fields got pc=%h pc4=%h jaddr=%h want 0", out_pc, out_pc_plus4, out_jaddr);
        end
    endtask

    task automatic test_single();
        in_valid = 1; in_instr = 32'h2128FFFC; in_pc = 32'h00400000; out_ready = 1;
        tick();
        in_valid = 0; in_instr = 32'hDEADBEEF; in_pc = 32'h12345678;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++;
        if ({out_opcode, out_rs, out_rt, out_imm} !== {6'h08, 5'd9, 5'd8, 16'hFFFC}) begin
            errors++; $display("FAIL single_fields got op=%h rs=%0d rt=%0d imm=%h want 08 9 8 fffc",
                               out_opcode, out_rs, out_rt, out_imm);
        end
        checks++;
        if (out_pc_plus4 !== 32'h00400004) begin errors++; $display("FAIL single_pc4 got %h want 00400004", out_pc_plus4); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_opcode !== 6'd0 || out_imm !== 16'd0 || out_pc !== 32'd0) begin
            errors++; $display("FAIL single_drain got valid=%0b op=%h imm=%h pc=%h want all 0", out_valid, out_opcode, out_imm, out_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [3];
        int n_got = 0;
        int pushed = 0;
        exp_pc[0] = 32'h1000; exp_pc[1] = 32'h1004; exp_pc[2] = 32'h1008;
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_pc = exp_pc[i]; in_instr = 32'hA0000000 + i;
            tick();
        end
        pushed = 2;
        in_pc = exp_pc[2]; in_instr = 32'hA0000002;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b want 0", in_ready); end
        tick(); tick();
        checks++;
        if (out_pc !== exp_pc[0] || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold got pc=%h ready=%0b want %h 0", out_pc, in_ready, exp_pc[0]);
        end
        out_ready = 1;
        for (int cyc = 0; cyc < 20 && n_got < 3; cyc++) begin
            logic take_out, take_in;
            take_out = out_valid;
            take_in  = in_valid && in_ready;
            if (take_out) begin
                checks++;
                if (out_pc !== exp_pc[n_got] || out_jaddr !== 26'(32'hA0000000 + n_got)) begin
                    errors++; $display("FAIL bp_order idx=%0d got pc=%h want %h", n_got, out_pc, exp_pc[n_got]);
                end
                n_got++;
            end
            @(posedge clk); #1;
            if (take_in) begin pushed++; in_valid = 0; end
        end
        checks++;
        if (n_got != 3 || pushed != 3) begin errors++; $display("FAIL bp_count got %0d/%0d want 3/3", n_got, pushed); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got valid=%0b pc=%h want 0", out_valid, out_pc); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_pc = 32'h2000 + 4 * i; in_instr = 32'h11110000 + i;
            tick();
        end
        in_valid = 1; in_pc = 32'h3000; in_instr = 32'h33333333; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got valid=%0b ready=%0b want 0 1", out_valid, in_ready);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got valid=%0b pc=%h want 0", out_valid, out_pc); end
        end
    endtask

    task automatic test_streaming();
        int bad_ready = 0, bad_data = 0;
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 100; i++) begin
            in_pc = 32'h00400000 + 4 * i; in_instr = $urandom;
            tick();
            if (in_ready !== 1'b1) bad_ready++;
            if (out_valid !== 1'b1 || out_pc !== in_pc || out_pc_plus4 !== in_pc + 4 ||
                {out_opcode, out_rs, out_rt, out_imm} !== in_instr) bad_data++;
        end
        in_valid = 0;
        checks++;
        if (bad_ready != 0) begin errors++; $display("FAIL stream_ready got %0d low cycles want 0", bad_ready); end
        checks++;
        if (bad_data != 0) begin errors++; $display("FAIL stream_data got %0d bad cycles want 0", bad_data); end
        tick();
    endtask

    task automatic test_wrap_and_async_reset();
        out_ready = 0; in_valid = 1; in_pc = 32'hFFFFFFFC; in_instr = 32'h0C000001;
        tick();
        in_pc = 32'h0; in_instr = 32'h1;
        checks++;
        if (out_pc !== 32'hFFFFFFFC || out_pc_plus4 !== 32'h00000000) begin
            errors++; $display("FAIL wrap got pc=%h pc4=%h want fffffffc 00000000", out_pc, out_pc_plus4);
        end
        tick(); tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'd0 || out_jaddr !== 26'd0) begin
            errors++; $display("FAIL async_reset got valid=%0b ready=%0b pc=%h want 0 1 0", out_valid, in_ready, out_pc);
        end
        in_valid = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    // Reference: a FIFO of at most two entries; ready means room after last cycle.
    task automatic test_random();
        logic [63:0] q[$];
        int bad = 0;
        bit  m_ready = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [63:0] head;
            bit fl, iv, orr;
            head = (q.size() > 0) ? q[0] : 64'd0;
            if (out_valid !== (q.size() > 0) || in_ready !== m_ready ||
                out_pc !== head[31:0] || out_pc_plus4 !== ((q.size() > 0) ? head[31:0] + 32'd4 : 32'd0) ||
                {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct} !== head[63:32] ||
                out_imm !== head[47:32] || out_jaddr !== head[57:32]) begin
                bad++;
                if (bad < 5) $display("FAIL random_cycle cyc=%0d got v=%0b r=%0b pc=%h want v=%0b r=%0b pc=%h",
                                      cyc, out_valid, in_ready, out_pc, q.size() > 0, m_ready, head[31:0]);
            end
            fl  = ($urandom_range(0, 19) == 0);
            iv  = ($urandom_range(0, 2) != 0);
            orr = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            flush = fl; in_valid = iv; out_ready = orr;
            in_instr = $urandom; in_pc = $urandom;
            if (fl) q.delete();
            else begin
                if (orr && q.size() > 0) void'(q.pop_front());
                if (iv && m_ready) q.push_back({in_instr, in_pc});
            end
            m_ready = (q.size() < 2);
            tick();
        end
        flush = 0; in_valid = 0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL random_model got %0d bad cycles want 0", bad); end
    endtask

`ifdef IFID_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 7; i++) begin
            in_pc = 32'h5000 + 4 * i; in_instr = i;
            tick();
        end
        in_valid = 0;
        checks++;
        if (perf_stall_cnt !== 32'd5 || perf_bubble_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_stall got stall=%0d bubble=%0d want 5 0", perf_stall_cnt, perf_bubble_cnt);
        end
        flush = 1;
        tick();
        flush = 0;
        checks++;
        if (perf_stall_cnt !== 32'd5 || perf_bubble_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_flush got stall=%0d bubble=%0d want 5 0", perf_stall_cnt, perf_bubble_cnt);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 0;
        checks++;
        if (perf_stall_cnt !== 32'd5 || perf_bubble_cnt !== 32'd3) begin
            errors++; $display("FAIL perf_bubble got stall=%0d bubble=%0d want 5 3", perf_stall_cnt, perf_bubble_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_streaming();
        test_wrap_and_async_reset();
        test_random();
`ifdef IFID_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_decode_stage.md
Name: if_id_decode_stage

Overview:
- Pipeline register between instruction fetch and the decode/sign-extension stage.
- Latches fetched instruction and PC through a 2-entry skid buffer with valid/ready handshakes.
- Splits the buffered instruction into MIPS fields; out_imm feeds the sign extender directly.
- Supports pipeline flush on branch/jump redirect.

Parameters:
- PC_W, 32, width of program counter and of out_pc / out_pc_plus4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  32  fetched instruction word.
- in_pc  input  PC_W  address of in_instr.
- flush  input  1  discard all buffered and incoming instructions.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head entry.
- out_pc  output  PC_W  PC of head entry.
- out_pc_plus4  output  PC_W  out_pc + 4, modulo 2^PC_W.
- out_opcode  output  6  instr[31:26].
- out_rs  output  5  instr[25:21].
- out_rt  output  5  instr[20:16].
- out_rd  output  5  instr[15:11].
- out_shamt  output  5  instr[10:6].
- out_funct  output  6  instr[5:0].
- out_imm  output  16  instr[15:0], raw (not extended).
- out_jaddr  output  26  instr[25:0].

Behaviour:
- Storage: head entry (H) and skid entry (S), each holding {valid, instr, pc}.
- Reset (rst_n low, asynchronous): H.valid = S.valid = 0, payloads = 0, in_ready = 1, out_valid = 0, all field outputs = 0.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Consume when out_valid && out_ready.
  - in_ready = !S.valid, registered. No combinational path from out_ready to in_ready.
- Latency: an accepted instruction appears on out_valid the next cycle if H is empty or being consumed; otherwise it waits in S.
- Ordering: strictly FIFO. S always moves into H before a new input can enter H.
- Per-cycle update, priority order:
  1. flush: H.valid = S.valid = 0. The input in that cycle is dropped even if in_valid && in_ready. in_ready = 1 next cycle. A consume in the same cycle is still a legal transfer.
  2. H empty, or consume: H takes S if S.valid (S cleared, and S takes the accepted input if any); otherwise H takes the accepted input. If neither is available, H.valid = 0.
  3. H full, no consume, accept: input goes to S (only possible while S empty).
- Full condition (H and S valid): in_ready = 0. Payload is held stable while out_ready is low.
- out_valid = H.valid.
- Field outputs and out_pc / out_pc_plus4 are combinational slices of H, forced to 0 when H.valid = 0.
- out_pc_plus4 wraps: PC 0xFFFFFFFC yields 0x00000000.
- Reset mid-operation: immediate clear of both entries regardless of handshake state.
- in_instr / in_pc are ignored when in_valid = 0.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0].
  - perf_stall_cnt increments each cycle with in_valid && !in_ready.
  - perf_bubble_cnt increments each cycle with out_ready && !out_valid.
  - Both saturate at 0xFFFFFFFF, reset to 0 via rst_n, and are unaffected by flush.
- Not defined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset then single transfer: in_instr = 0x2128FFFC, in_pc = 0x00400000, out_ready = 1 → next cycle out_valid = 1, out_opcode = 0x08, out_rs = 9, out_rt = 8, out_imm = 0xFFFC, out_pc_plus4 = 0x00400004; following cycle out_valid = 0 and fields = 0.
- Backpressure: out_ready = 0, push A and B → in_ready = 0 after B; C held off. Raise out_ready → A, B, C delivered in order, one per cycle, no loss or duplication.
- Flush with full buffer plus incoming in_valid → next cycle out_valid = 0, in_ready = 1, incoming instruction never appears.
- Streaming: in_valid = out_ready = 1 for 100 cycles, sequential PCs → throughput 1/cycle, in_ready constantly 1, latency 1.
- Wrap: in_pc = 0xFFFFFFFC → out_pc_plus4 = 0x00000000. Assert rst_n low mid-stall → outputs 0 asynchronously.
- With IFID_PERF_CNT_EN: 5 stalled cycles and 3 idle out_ready cycles → perf_stall_cnt = 5, perf_bubble_cnt = 3; flush leaves both unchanged.
